// File: rtl/arcade_input_cond.sv
// Player input conditioning: PS/2 held-key decode merged with both HPS joysticks,
// plus a rate-limited coin pulse shaper with a small pending-credit queue.
module arcade_input_cond #(
  parameter int COIN_CYCLES = 1_000_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  output logic [7:0]  btn1,
  output logic [7:0]  btn2,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic [1:0]  coin_pending
);

  localparam int MAX_CYCLES = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  // Held-key slots: [7:0] player 1, [15:8] player 2 (joy bit order),
  // [17:16] start1, [19:18] start2, [22:20] coin.
  localparam int NUM_KEYS = 23;
  localparam logic [7:0] KEY_CODE [NUM_KEYS] = '{
    8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h12,
    8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h21, 8'h1D,
    8'h05, 8'h16, 8'h06, 8'h1E, 8'h76, 8'h2E, 8'h36
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } coin_state_t;

  logic                tgl_q;
  logic                key_event;
  logic [NUM_KEYS-1:0] key_hit;
  logic [NUM_KEYS-1:0] held_q;
  logic                coin_raw;
  logic                raw_q;
  logic                coin_rise;
  coin_state_t         state_q;
  logic [CW-1:0]       cnt_q;
  logic                unused_bits;

  assign key_event = ps2_key[10] ^ tgl_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key_hit
      assign key_hit[gi] = key_event && (ps2_key[7:0] == KEY_CODE[gi]);
    end
  endgenerate

  // The extended flag is deliberately ignored so numpad and E0 arrows share a slot.
  assign unused_bits = ^{ps2_key[8], joy1[15:11], joy2[15:11]};

  always_ff @(posedge clk_sys) begin
    tgl_q <= ps2_key[10];
    if (reset) begin
      held_q <= '0;
    end else begin
      held_q <= (held_q & ~key_hit) | (key_hit & {NUM_KEYS{ps2_key[9]}});
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn1   <= '0;
      btn2   <= '0;
      start1 <= 1'b0;
      start2 <= 1'b0;
    end else begin
      btn1   <= held_q[7:0]  | joy1[7:0];
      btn2   <= held_q[15:8] | joy2[7:0];
      start1 <= (|held_q[17:16]) | joy1[8] | joy2[8];
      start2 <= (|held_q[19:18]) | joy1[9] | joy2[9];
    end
  end

  assign coin_raw  = (|held_q[22:20]) | joy1[10] | joy2[10];
  assign coin_rise = coin_raw & ~raw_q;

  // raw_q tracks coin_raw even in reset so a coin held through reset never fires.
  always_ff @(posedge clk_sys) begin
    raw_q <= coin_raw;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      coin1        <= 1'b0;
      coin_pending <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (coin_rise) begin
            state_q <= S_PULSE;
            cnt_q   <= COIN_LOAD;
            coin1   <= 1'b1;
          end
        end
        S_PULSE: begin
          if (coin_rise && coin_pending != 2'd3) begin
            coin_pending <= coin_pending + 2'd1;
          end
          if (cnt_q == '0) begin
            state_q <= S_GAP;
            cnt_q   <= GAP_LOAD;
            coin1   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            if (coin_rise && coin_pending != 2'd3) begin
              coin_pending <= coin_pending + 2'd1;
            end
          end else if (coin_pending != 2'd0 || coin_rise) begin
            // A rise on the gap-end edge cancels the dequeue (or starts the pulse directly).
            state_q <= S_PULSE;
            cnt_q   <= COIN_LOAD;
            coin1   <= 1'b1;
            if (!coin_rise) begin
              coin_pending <= coin_pending - 2'd1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          coin1   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond with short coin timing (pulse 4, gap 3).
module tb_arcade_input_cond;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic [7:0]  btn1;
  logic [7:0]  btn2;
  logic        start1;
  logic        start2;
  logic        coin1;
  logic [1:0]  coin_pending;

  int checks   = 0;
  int failures = 0;

  logic       coin_hist [50];
  logic [1:0] pend_hist [50];

  always #5 clk_sys = ~clk_sys;

  arcade_input_cond #(
    .COIN_CYCLES(4),
    .GAP_CYCLES (3)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .joy1        (joy1),
    .joy2        (joy2),
    .btn1        (btn1),
    .btn2        (btn2),
    .start1      (start1),
    .start2      (start2),
    .coin1       (coin1),
    .coin_pending(coin_pending)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  initial begin
    int rises;
    int last_rise;
    logic [1:0] peak;

    reset   = 1'b1;
    ps2_key = '0;
    joy1    = '0;
    joy2    = '0;
    tick(2);
    check("rst_btn1", btn1, 8'h00);
    check("rst_btn2", btn2, 8'h00);
    check("rst_start", {6'd0, start2, start1}, 8'h00);
    check("rst_coin1", {7'd0, coin1}, 8'h00);
    check("rst_pending", {6'd0, coin_pending}, 8'h00);
    reset = 1'b0;
    tick();

    // Start key make then break: start1 follows on the second edge each time.
    send_key(1'b1, 1'b0, 8'h05);
    tick();
    check("start_make_k", {7'd0, start1}, 8'h00);
    tick();
    check("start_make_k1", {7'd0, start1}, 8'h01);
    check("start_others", {btn1 | btn2, 6'd0, start2, coin1}, {8'h00, 8'h00});
    send_key(1'b0, 1'b0, 8'h05);
    tick();
    check("start_break_k", {7'd0, start1}, 8'h01);
    tick();
    check("start_break_k1", {7'd0, start1}, 8'h00);

    // Extended left arrow maps to player 1 left; an idle toggle changes nothing.
    send_key(1'b1, 1'b1, 8'h6B);
    tick(2);
    check("ext_left", btn1, 8'h02);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_hold", {btn1, btn2}, {8'h02, 8'h00});
    end
    send_key(1'b0, 1'b1, 8'h6B);
    tick(2);
    check("ext_left_rel", btn1, 8'h00);

    send_key(1'b1, 1'b0, 8'h1C);
    tick(2);
    check("p2_fireA", btn2, 8'h10);
    send_key(1'b0, 1'b0, 8'h1C);
    tick(2);
    check("p2_fireA_rel", btn2, 8'h00);

    send_key(1'b1, 1'b0, 8'h1A);
    tick(2);
    check("unlisted", {btn1 | btn2, 5'd0, start1, start2, coin1}, {8'h00, 8'h00});
    send_key(1'b0, 1'b0, 8'h1A);
    tick();

    // Joystick bits appear on the first edge after they change.
    joy1 = 16'h0001;
    joy2 = 16'h0100;
    tick();
    check("joy_btn1", btn1, 8'h01);
    check("joy_start1", {btn2, 7'd0, start1}, {8'h00, 8'h01});
    joy1 = '0;
    joy2 = '0;
    tick();
    check("joy_clear", {btn1, 7'd0, start1}, {8'h00, 8'h00});

    // Held joystick coin: one 4-cycle pulse, nothing more while held.
    joy2[10] = 1'b1;
    tick();
    check("held_p0", {7'd0, coin1}, 8'h01);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("held_pulse", {7'd0, coin1}, 8'h01);
    end
    tick();
    check("held_end", {7'd0, coin1}, 8'h00);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("held_quiet", {6'd0, coin1, 1'b0}, {6'd0, 1'b0, 1'b0});
    end
    check("held_pending", {6'd0, coin_pending}, 8'h00);
    joy2[10] = 1'b0;
    tick(5);

    // Keyboard coin key: pulse one edge after the held key updates.
    send_key(1'b1, 1'b0, 8'h76);
    tick();
    check("kcoin_k", {7'd0, coin1}, 8'h00);
    tick();
    check("kcoin_k1", {7'd0, coin1}, 8'h01);
    send_key(1'b0, 1'b0, 8'h76);
    tick(12);

    // Coin train, rises every 2 cycles at t=0..12. The fifth rise lands just after
    // the first dequeue, so the last two rises are the ones dropped at the cap.
    // Pulses start at t=0,7,14,21,28; pending 1@2 2@4 3@6 2@7 3@8 2@14 1@21 0@28.
    for (int t = 0; t < 50; t++) begin
      joy1[10] = (t < 13) && (t % 2 == 0);
      tick();
      coin_hist[t] = coin1;
      pend_hist[t] = coin_pending;
    end
    joy1[10] = 1'b0;
    rises     = 0;
    last_rise = -7;
    peak      = 2'd0;
    for (int t = 0; t < 50; t++) begin
      logic       exp_coin;
      logic [1:0] exp_pend;
      exp_coin = (t < 32) && (t % 7 < 4);
      if (t < 2)       exp_pend = 2'd0;
      else if (t < 4)  exp_pend = 2'd1;
      else if (t < 6)  exp_pend = 2'd2;
      else if (t == 6) exp_pend = 2'd3;
      else if (t == 7) exp_pend = 2'd2;
      else if (t < 14) exp_pend = 2'd3;
      else if (t < 21) exp_pend = 2'd2;
      else if (t < 28) exp_pend = 2'd1;
      else             exp_pend = 2'd0;
      check("train_coin1", {7'd0, coin_hist[t]}, {7'd0, exp_coin});
      check("train_pending", {6'd0, pend_hist[t]}, {6'd0, exp_pend});
      if (pend_hist[t] > peak) peak = pend_hist[t];
      if (coin_hist[t] && (t == 0 || !coin_hist[t-1])) begin
        rises++;
        check("train_period", 8'(t - last_rise), 8'd7);
        last_rise = t;
      end
    end
    check("train_peak", {6'd0, peak}, 8'h03);
    check("train_pulses", 8'(rises), 8'd5);

    // Reset mid-pulse with two credits queued (same train, stopped at t=14).
    for (int t = 0; t < 15; t++) begin
      joy1[10] = (t < 9) && (t % 2 == 0);
      tick();
    end
    check("mid_coin1", {7'd0, coin1}, 8'h01);
    check("mid_pending", {6'd0, coin_pending}, 8'h02);
    joy1[10] = 1'b1;
    reset    = 1'b1;
    tick();
    check("rst_mid_coin1", {7'd0, coin1}, 8'h00);
    check("rst_mid_pending", {6'd0, coin_pending}, 8'h00);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_held_quiet", {6'd0, coin_pending, coin1}, 8'h00);
    end
    joy1[10] = 1'b0;
    tick();
    joy1[10] = 1'b1;
    tick();
    check("rst_repress", {7'd0, coin1}, 8'h01);
    joy1[10] = 1'b0;
    tick(10);

    // Reset released with the toggle already high and a start code present.
    reset   = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h05};
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_tgl_start1", {7'd0, start1}, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
